// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   // Wide enough for any control bundle; users size-cast to CTRL_W.
   localparam int unsigned CTRL_NOP_W = 64;
   localparam logic [CTRL_NOP_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with registered ready; head entry drives the outputs.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned DATA_W = 96
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              ready_o,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o
);

   skid_state_e       state_q, state_d;
   logic              rdy_q;
   logic [CTRL_W-1:0] head_ctrl_q, tail_ctrl_q;
   logic [DATA_W-1:0] head_data_q, tail_data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d != ST_TWO);
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: if (push_i) state_d = ST_ONE;
            ST_ONE: begin
               if (push_i && !pop_i)      state_d = ST_TWO;
               else if (pop_i && !push_i) state_d = ST_EMPTY;
            end
            ST_TWO:   if (pop_i) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   // Flush only neutralises control; data registers keep their contents.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_ctrl_q <= '0;
         tail_ctrl_q <= '0;
         head_data_q <= '0;
         tail_data_q <= '0;
      end else if (flush_i) begin
         head_ctrl_q <= CTRL_W'(CTRL_NOP);
         tail_ctrl_q <= CTRL_W'(CTRL_NOP);
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (push_i) begin
                  head_ctrl_q <= in_ctrl_i;
                  head_data_q <= in_data_i;
               end
            end
            ST_ONE: begin
               if (push_i && pop_i) begin
                  head_ctrl_q <= in_ctrl_i;
                  head_data_q <= in_data_i;
               end else if (push_i) begin
                  tail_ctrl_q <= in_ctrl_i;
                  tail_data_q <= in_data_i;
               end
            end
            ST_TWO: begin
               if (pop_i) begin
                  head_ctrl_q <= tail_ctrl_q;
                  head_data_q <= tail_data_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign ready_o = rdy_q;
   assign valid_o = (state_q != ST_EMPTY);
   assign ctrl_o  = head_ctrl_q;
   assign data_o  = head_data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with flush, ctrl masking and bubble counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with registered ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned DATA_W = 96,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   logic              push;
   logic              pop;
   logic              head_valid;
   logic [CTRL_W-1:0] head_ctrl;
   logic [DATA_W-1:0] head_data;
   logic [CNT_W-1:0]  bubble_q;

   assign push = in_valid_i & in_ready_o & ~flush_i;
   assign pop  = head_valid & out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
   pipe_skid_buf #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
   ) u_skid (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (flush_i),
      .push_i    (push),
      .pop_i     (pop),
      .in_ctrl_i (in_ctrl_i),
      .in_data_i (in_data_i),
      .ready_o   (in_ready_o),
      .valid_o   (head_valid),
      .ctrl_o    (head_ctrl),
      .data_o    (head_data)
   );
`else
   logic              valid_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_W'(CTRL_NOP);
      end else if (push) begin
         valid_q <= 1'b1;
         ctrl_q  <= in_ctrl_i;
         data_q  <= in_data_i;
      end else if (pop) begin
         valid_q <= 1'b0;
      end
   end

   assign in_ready_o = ~valid_q | out_ready_i;
   assign head_valid = valid_q;
   assign head_ctrl  = ctrl_q;
   assign head_data  = data_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bubble_q <= '0;
      end else if (out_ready_i && !head_valid && (bubble_q != '1)) begin
         bubble_q <= bubble_q + 1'b1;
      end
   end

   assign out_valid_o  = head_valid;
   assign out_ctrl_o   = head_valid ? head_ctrl : CTRL_W'(CTRL_NOP);
   assign out_data_o   = head_data;
   assign bubble_cnt_o = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_pipe_stage_reg;

   localparam int unsigned CW = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned NW = 4;
`ifdef PIPE_STAGE_SKID_EN
   localparam int unsigned CAP = 2;
`else
   localparam int unsigned CAP = 1;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          flush_i = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [CW-1:0] in_ctrl_i = '0;
   logic [DW-1:0] in_data_i = '0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [CW-1:0] out_ctrl_o;
   logic [DW-1:0] out_data_o;
   logic [NW-1:0] bubble_cnt_o;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(
      .CTRL_W (CW),
      .DATA_W (DW),
      .CNT_W  (NW)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_ctrl_i    (in_ctrl_i),
      .in_data_i    (in_data_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_ctrl_o   (out_ctrl_o),
      .out_data_o   (out_data_o),
      .bubble_cnt_o (bubble_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          mq[$];
   logic [DW-1:0] m_held;
   int unsigned   m_bub;

   function automatic logic m_ready();
      if (CAP == 2) return (mq.size() < 2);
      return (mq.size() == 0) || out_ready_i;
   endfunction

   // Reference model: a FIFO of capacity CAP plus a saturating bubble tally.
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mq.delete();
         m_held = '0;
         m_bub  = 0;
      end else begin
         logic do_push, do_pop;
         ent_t e;
         do_push = in_valid_i && m_ready() && !flush_i;
         do_pop  = (mq.size() > 0) && out_ready_i;
         if (out_ready_i && mq.size() == 0 && m_bub < (2**NW - 1)) m_bub++;
         if (mq.size() > 0) m_held = mq[0].d;
         if (flush_i) begin
            mq.delete();
         end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
               e.c = in_ctrl_i;
               e.d = in_data_i;
               mq.push_back(e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_i) begin
      chk("m_valid", 64'(out_valid_o), 64'(mq.size() > 0));
      chk("m_ctrl", 64'(out_ctrl_o), (mq.size() > 0) ? 64'(mq[0].c) : 64'd0);
      chk("m_data", 64'(out_data_o), (mq.size() > 0) ? 64'(mq[0].d) : 64'(m_held));
      chk("m_ready", 64'(in_ready_o), 64'(m_ready()));
      chk("m_bubble", 64'(bubble_cnt_o), 64'(m_bub));
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
      in_valid_i = v;
      in_ctrl_i  = c;
      in_data_i  = d;
   endtask

   initial begin
      repeat (3) tick();
      chk("reset_valid", 64'(out_valid_o), 64'd0);
      chk("reset_data", 64'(out_data_o), 64'd0);
      rst_i = 1'b0;
      tick();
      chk("reset_ready", 64'(in_ready_o), 64'd1);

      // Streaming 0..7 with downstream always ready
      out_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, CW'(8'h40 + i), DW'(i));
         tick();
         chk("stream_valid", 64'(out_valid_o), 64'd1);
         chk("stream_data", 64'(out_data_o), 64'(i));
         chk("stream_ctrl", 64'(out_ctrl_o), 64'(8'h40 + i));
      end
      chk("stream_bubble", 64'(bubble_cnt_o), 64'd1);
      drive(1'b0, '0, '0);
      repeat (2) tick();

      // Backpressure
      out_ready_i = 1'b0;
      drive(1'b1, 8'h50, 32'd0);
      tick();
`ifdef PIPE_STAGE_SKID_EN
      drive(1'b1, 8'h51, 32'd1);
      tick();
      chk("bp_ready_low", 64'(in_ready_o), 64'd0);
      drive(1'b1, 8'h52, 32'd2);
      tick();
      chk("bp_hold_ready", 64'(in_ready_o), 64'd0);
      chk("bp_head0", 64'(out_data_o), 64'd0);
      out_ready_i = 1'b1;
      tick();
      chk("bp_head1", 64'(out_data_o), 64'd1);
      chk("bp_ready_back", 64'(in_ready_o), 64'd1);
      tick();
      chk("bp_head2", 64'(out_data_o), 64'd2);
      chk("bp_ctrl2", 64'(out_ctrl_o), 64'h52);
`else
      drive(1'b1, 8'h51, 32'd1);
      #1;
      chk("bp_ready_low", 64'(in_ready_o), 64'd0);
      out_ready_i = 1'b1;
      #1;
      chk("comb_ready", 64'(in_ready_o), 64'd1);
      tick();
      chk("bp_head1", 64'(out_data_o), 64'd1);
`endif
      drive(1'b0, '0, '0);
      tick();
      chk("bp_drained", 64'(out_valid_o), 64'd0);

      // Flush while holding entries, with an input presented
      out_ready_i = 1'b0;
      drive(1'b1, 8'h60, 32'h10);
      tick();
      drive(1'b1, 8'h61, 32'h11);
      tick();
      flush_i = 1'b1;
      drive(1'b1, 8'h6A, 32'hAA);
      tick();
      flush_i = 1'b0;
      chk("flush_valid", 64'(out_valid_o), 64'd0);
      chk("flush_ctrl", 64'(out_ctrl_o), 64'd0);
      chk("flush_ready", 64'(in_ready_o), 64'd1);
      drive(1'b0, '0, '0);
      out_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flush_no_leak", 64'(out_valid_o), 64'd0);
      end

      // Bubble saturation
      repeat (20) tick();
      chk("bubble_sat", 64'(bubble_cnt_o), 64'd15);
      tick();
      chk("bubble_hold", 64'(bubble_cnt_o), 64'd15);

      // Async reset between edges while holding entries
      out_ready_i = 1'b0;
      drive(1'b1, 8'h70, 32'h20);
      tick();
      drive(1'b1, 8'h71, 32'h21);
      tick();
      drive(1'b0, '0, '0);
      #2;
      rst_i = 1'b1;
      #1;
      chk("arst_valid", 64'(out_valid_o), 64'd0);
      chk("arst_bubble", 64'(bubble_cnt_o), 64'd0);
      chk("arst_data", 64'(out_data_o), 64'd0);
      #2;
      rst_i = 1'b0;
      drive(1'b1, 8'h73, 32'h30);
      tick();
      chk("arst_first_valid", 64'(out_valid_o), 64'd1);
      chk("arst_first_data", 64'(out_data_o), 64'h30);

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, CW'($urandom), DW'($urandom));
         out_ready_i = ($urandom_range(0, 2) != 0);
         flush_i     = ($urandom_range(0, 19) == 0);
         tick();
      end
      drive(1'b0, '0, '0);
      flush_i = 1'b0;
      out_ready_i = 1'b1;
      repeat (3) tick();

      @(negedge clk_i);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
